// File: rtl/codemem_loader_pkg.sv
// Shared definitions for the code memory write path.
// Holds the loader FSM state encoding and the width check that ties the
// instruction width to the stream beat width. The code memory wrapper uses
// the same check.
package codemem_loader_pkg;

    typedef enum logic [1:0] {
        S_HI    = 2'd0,
        S_LO    = 2'd1,
        S_DRAIN = 2'd2
    } loader_state_e;

    // One instruction is exactly two stream beats.
    function automatic bit widths_ok(input int data_width, input int in_width);
        return data_width == 2 * in_width;
    endfunction

endpackage

// File: rtl/codemem_loader_if.sv
// AXI-Stream style half-instruction channel into the code memory loader.
//   s_tdata  : half-instruction beat
//   s_tvalid : beat valid
//   s_tlast  : last beat of program
//   s_tready : loader can accept a beat
// master drives the beats, slave (the loader) returns s_tready.
interface codemem_loader_if #(
    parameter int IN_WIDTH = 32
);
    logic [IN_WIDTH-1:0] s_tdata;
    logic                s_tvalid;
    logic                s_tlast;
    logic                s_tready;

    modport master (
        output s_tdata,
        output s_tvalid,
        output s_tlast,
        input  s_tready
    );

    modport slave (
        input  s_tdata,
        input  s_tvalid,
        input  s_tlast,
        output s_tready
    );
endinterface

// File: rtl/codemem_loader.sv
// Code memory loader.
// Pairs 32-bit stream beats into 64-bit instructions (first beat is the
// upper half) and writes them sequentially from address 0. Reports program
// completion with its length, plus sticky framing/overflow errors.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   s          : beat stream (slave side); s_tready = load_en & ~rst
//   load_en    : controller permits loading; low stalls everything
//   wr_addr/wr_data/wr_en : registered code memory write port
//   prog_done  : one-cycle pulse with the final write of a good program
//   prog_len   : instruction count of last completed program
//   err_odd    : sticky, tlast on a first-half beat
//   err_ovf    : sticky, program longer than the memory
//   err_clr    : clears both error flags (a new error the same cycle wins)
//
// state   | meaning
// S_HI    | waiting for the upper half of an instruction
// S_LO    | upper half held, waiting for the lower half
// S_DRAIN | overflowed, discarding beats up to tlast
module codemem_loader
    import codemem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 64,
    parameter int IN_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    codemem_loader_if.slave       s,
    input  logic                  load_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_en,
    output logic                  prog_done,
    output logic [ADDR_WIDTH:0]   prog_len,
    output logic                  err_odd,
    output logic                  err_ovf,
    input  logic                  err_clr
);

    localparam bit WIDTHS_OK = widths_ok(DATA_WIDTH, IN_WIDTH);
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = DEPTH[ADDR_WIDTH:0];

    generate
        if (!WIDTHS_OK) begin : g_width_check
            $error("codemem_loader: DATA_WIDTH must be 2*IN_WIDTH");
        end
    endgenerate

    loader_state_e         state_q, state_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic [IN_WIDTH-1:0]   hi_q, hi_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  wr_en_q, wr_en_d;
    logic                  prog_done_q, prog_done_d;
    logic [ADDR_WIDTH:0]   prog_len_q, prog_len_d;
    logic                  err_odd_q, err_odd_d;
    logic                  err_ovf_q, err_ovf_d;
    logic                  accept;

    assign s.s_tready = load_en & ~rst;
    assign accept     = s.s_tvalid & s.s_tready;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hi_d        = hi_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        wr_en_d     = 1'b0;
        prog_done_d = 1'b0;
        prog_len_d  = prog_len_q;
        // Clear first so that an error raised below overrides it.
        err_odd_d   = err_clr ? 1'b0 : err_odd_q;
        err_ovf_d   = err_clr ? 1'b0 : err_ovf_q;

        case (state_q)
            S_HI: begin
                if (accept) begin
                    if (s.s_tlast) begin
                        err_odd_d = 1'b1;
                        cnt_d     = '0;
                    end else begin
                        hi_d    = s.s_tdata;
                        state_d = S_LO;
                    end
                end
            end
            S_LO: begin
                if (accept) begin
                    if (cnt_q < DEPTH_C) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = cnt_q[ADDR_WIDTH-1:0];
                        wr_data_d = {hi_q, s.s_tdata};
                        cnt_d     = cnt_q + 1'b1;
                        state_d   = S_HI;
                        if (s.s_tlast) begin
                            prog_done_d = 1'b1;
                            prog_len_d  = cnt_q + 1'b1;
                            cnt_d       = '0;
                        end
                    end else begin
                        err_ovf_d = 1'b1;
                        if (s.s_tlast) begin
                            cnt_d   = '0;
                            state_d = S_HI;
                        end else begin
                            state_d = S_DRAIN;
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (accept && s.s_tlast) begin
                    cnt_d   = '0;
                    state_d = S_HI;
                end
            end
            default: begin
                state_d = S_HI;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_HI;
            cnt_q       <= '0;
            hi_q        <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            wr_en_q     <= 1'b0;
            prog_done_q <= 1'b0;
            prog_len_q  <= '0;
            err_odd_q   <= 1'b0;
            err_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hi_q        <= hi_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            wr_en_q     <= wr_en_d;
            prog_done_q <= prog_done_d;
            prog_len_q  <= prog_len_d;
            err_odd_q   <= err_odd_d;
            err_ovf_q   <= err_ovf_d;
        end
    end

    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign wr_en     = wr_en_q;
    assign prog_done = prog_done_q;
    assign prog_len  = prog_len_q;
    assign err_odd   = err_odd_q;
    assign err_ovf   = err_ovf_q;

endmodule

// File: doc/codemem_loader.md
# codemem_loader

Upstream write-side stage for the instruction memory. Accepts the filter program as a 32-bit AXI-Stream of half-instructions and pairs each two beats into one 64-bit instruction. It writes instructions sequentially from address 0 into the code memory's write port. It reports program completion, length and framing errors to the packet-filter controller.

## Interface
Parameters:
- ADDR_WIDTH, 10, code memory address width; DEPTH = 2**ADDR_WIDTH instructions
- DATA_WIDTH, 64, instruction width; must equal 2*IN_WIDTH
- IN_WIDTH, 32, stream beat width

Ports:
- clk  in  1  sole clock; all state on rising edge
- rst  in  1  synchronous, active-high reset
- s_tdata  in  IN_WIDTH  half-instruction beat
- s_tvalid  in  1  beat valid
- s_tlast  in  1  last beat of program
- s_tready  out  IN_WIDTH-independent, 1  = load_en & ~rst (combinational)
- load_en  in  1  controller permits loading (CPU not reading code)
- wr_addr  out  ADDR_WIDTH  code memory write address (registered)
- wr_data  out  DATA_WIDTH  code memory write data (registered)
- wr_en  out  1  one-cycle write strobe (registered)
- prog_done  out  1  one-cycle pulse: well-formed program fully written
- prog_len  out  ADDR_WIDTH+1  instruction count of last completed program; held until next prog_done
- err_odd  out  1  sticky: tlast arrived on a first-half beat
- err_ovf  out  1  sticky: program exceeded DEPTH instructions
- err_clr  in  1  clears err_odd/err_ovf next cycle

## Operation
- Beat accepted when s_tvalid & s_tready. load_en low stalls acceptance; all state held.
- Word order: first beat of a pair -> wr_data[63:32], second -> wr_data[31:0].
- Word counter cnt, ADDR_WIDTH+1 bits, counts instructions written in current program.
- FSM states:
  - S_HI: await first half. Accept -> latch into hi register, go S_LO. If tlast on this beat -> set err_odd, cnt<=0, stay S_HI, no write, no prog_done.
  - S_LO: await second half. Accept -> if cnt < DEPTH, issue write at wr_addr=cnt[ADDR_WIDTH-1:0], cnt<=cnt+1. If tlast -> prog_done, prog_len<=cnt+1, cnt<=0, S_HI; else S_HI. If cnt == DEPTH -> no write, set err_ovf; if tlast, cnt<=0 and S_HI, else S_DRAIN.
  - S_DRAIN: accept and discard beats; on tlast cnt<=0, S_HI, no prog_done.
- A program of exactly DEPTH instructions is legal; prog_len = DEPTH.
- err_clr and a simultaneous error-set event: set wins.
- Reset mid-program: partial program abandoned, no prog_done; memory contents untouched.

## Timing
- Reset values: wr_en=0, wr_addr=0, wr_data=0, prog_done=0, prog_len=0, err_odd=0, err_ovf=0; state S_HI, cnt=0.
- Write latency: wr_en/wr_addr/wr_data valid the cycle after the second-half beat is accepted.
- prog_done asserts the same cycle as the final wr_en; prog_len updates that cycle.
- Full throughput: one beat per cycle; one write every two cycles sustained.
- Error flags assert the cycle after the offending beat.

## Structure
- Shared package: state encoding (S_HI, S_LO, S_DRAIN) and the DATA_WIDTH==2*IN_WIDTH check constant, shared with the code memory wrapper.
- No sub-module required; single module, one FSM plus datapath registers.

## Test plan
- Reset, load_en=1, send 4 beats 0xA,0xB,0xC,0xD (tlast on 4th) -> writes (addr0,0x0000000A_0000000B),(addr1,0x0000000C_0000000D); prog_done with final write; prog_len=2.
- Same stream with load_en low for 3 cycles between beats 2 and 3 -> s_tready low during stall, identical writes, no duplicate.
- 3 beats, tlast on 3rd -> one write at addr0, err_odd=1, no prog_done; next 2-beat program writes addr0.
- ADDR_WIDTH=2, 5 instructions -> addrs 0..3 written, err_ovf=1, 5th dropped, no prog_done; exactly 4 instructions -> prog_done, prog_len=4.
- rst asserted after 3 beats -> no writes beyond addr0, no prog_done; subsequent program starts at addr0.
- err_clr pulse after err_odd -> flag 0 next cycle; err_clr coincident with new odd-tlast -> flag stays 1.
